mvtr_mon: RTL
=============

MVTR_MON -- requirements
Module: mvtr_mon

Interface
REQ-001 Parameter M, default 3: number of replicas voted; legal range 3..7.
REQ-002 Parameter N, default 4: width of one replica vector.
REQ-003 Parameter CNT_W, default 8: width of each per-replica mismatch counter.
REQ-004 Parameter PERSIST, default 4: consecutive mismatching samples that declare a replica faulty; legal range 1..15.
REQ-005 clk_i  in  1: single clock; all state rising-edge.
REQ-006 rstn_i  in  1: reset, asynchronous assert, active-low.
REQ-007 vld_i  in  1: vtr_i holds a sample this cycle.
REQ-008 vtr_i  in  M*N: replica h occupies bits [h*N +: N].
REQ-009 mask_en_i  in  1: when 1, replicas with fault_o set are excluded from the vote.
REQ-010 clr_i  in  1: synchronous clear of counters, run lengths and fault flags.
REQ-011 vld_o  out  1: vtr_o/warn_o carry the result of a sample.
REQ-012 vtr_o  out  N: registered voted vector.
REQ-013 warn_o  out  1: at least one replica disagreed with the vote for this sample.
REQ-014 fault_o  out  M: sticky per-replica faulty flag.
REQ-015 err_cnt_o  out  M*CNT_W: per-replica mismatch count, replica h at [h*CNT_W +: CNT_W].

Function
REQ-016 Latency: a sample accepted with vld_i=1 in cycle t SHALL appear on vtr_o/warn_o with vld_o=1 in cycle t+1; vld_o=0 otherwise; vtr_o holds its last value while vld_o=0.
REQ-017 Active set: replicas with fault_o=0 if mask_en_i=1, else all M; if mask_en_i=1 and every replica is faulty, the active set SHALL be all M.
REQ-018 Per bit, with A active replicas and K of them at 1: output 1 if 2K>A, 0 if 2K<A; on a tie (2K=A) output the bit of the lowest-indexed active replica.
REQ-019 A replica mismatches when any of its N bits differs from the voted vector of the same sample; masked replicas are still compared.
REQ-020 warn_o SHALL be 1 iff any replica mismatches for that sample; warn_o=0 when vld_o=0.
REQ-021 err_cnt for replica h SHALL increment by 1 per valid mismatching sample, saturating at 2^CNT_W-1.
REQ-022 Per-replica run length SHALL increment on a valid mismatching sample, reset to 0 on a valid matching sample, and hold when vld_i=0.
REQ-023 When run length reaches PERSIST, fault_o[h] SHALL be set in the same cycle err_cnt updates; once set it stays set until clr_i or reset.
REQ-024 Counters, run lengths and fault_o SHALL be updated one cycle after sample acceptance, aligned with vld_o.
REQ-025 clr_i=1 SHALL zero all err_cnt, run lengths and fault_o next edge; clear wins over a simultaneous increment or fault set; the vote pipeline is unaffected.
REQ-026 mask_en_i and fault_o are sampled in the cycle the vote is computed; a fault set by sample t affects vote of sample t+1 onward, never sample t.

Reset
REQ-027 rstn_i low SHALL asynchronously force vld_o=0, vtr_o=0, warn_o=0, fault_o=0, all err_cnt=0, all run lengths=0.
REQ-028 A sample in flight when reset asserts SHALL be discarded; first vld_o after release corresponds to a sample accepted after release.

Structure
REQ-029 Shared package mvtr_pkg SHALL hold the count-ones function, the run-length width constant ($clog2(PERSIST+1)) and the masked-majority tie rule function.
REQ-030 One sub-module mvtr_rep_mon SHALL implement a single replica's mismatch counter, run-length counter and sticky fault flag, instantiated M times.

Verification (M=3, N=4, CNT_W=4, PERSIST=4)
REQ-031 Replicas 5,5,5 valid -> next cycle vtr_o=5, warn_o=0, counters unchanged.
REQ-032 Replicas 5,5,7 valid for 4 consecutive samples -> vtr_o=5, warn_o=1 each; err_cnt[2]=4, fault_o=3'b100 after 4th result.
REQ-033 After REQ-032 with mask_en_i=1, replicas 5,7,0 -> active {0,1}, bit-1 tie takes replica 0 -> vtr_o=5; err_cnt[1] and [2] increment.
REQ-034 Replica 1 mismatches 20 samples -> err_cnt[1] saturates at 15; mismatch, match, mismatch x3 -> fault_o[1] not set at 4 non-consecutive.
REQ-035 clr_i asserted in same cycle as a mismatching sample -> counters and fault_o zero next cycle; vtr_o still produced with vld_o=1.
REQ-036 rstn_i pulsed low mid-stream with vld_i=1 -> vld_o, vtr_o, fault_o, err_cnt zero immediately; no stale vld_o after release.

Source files
------------

// File: rtl/mvtr_pkg.sv
// Shared types and helpers for the replica vote monitor.
// Bit counting, run-length sizing and the masked-majority tie rule.
package mvtr_pkg;

  localparam int MAX_M = 8;

  function automatic int runlen_w(input int persist);
    return $clog2(persist + 1);
  endfunction

  function automatic logic [3:0] popcnt(
    input logic [MAX_M-1:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_M; i++)
      c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Ties resolve to the lowest-indexed active replica.
  function automatic logic maj_bit(
    input logic [MAX_M-1:0] b,
    input logic [MAX_M-1:0] act
  );
    logic [4:0] a2;
    logic [4:0] k2;
    logic       tie;
    logic       found;
    a2    = {1'b0, popcnt(act)};
    k2    = {popcnt(b & act), 1'b0};
    tie   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < MAX_M; i++) begin
      if (act[i] && !found) begin
        tie   = b[i];
        found = 1'b1;
      end
    end
    if (k2 > a2)
      return 1'b1;
    else if (k2 < a2)
      return 1'b0;
    else
      return tie;
  endfunction

endpackage

// File: rtl/mvtr_if.sv
// Sample/result bundle between the voter and its environment.
// slave is the monitor side, master the driver side.
interface mvtr_if #(
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             vld_i;
  logic [M*N-1:0]   vtr_i;
  logic             mask_en_i;
  logic             clr_i;
  logic             vld_o;
  logic [N-1:0]     vtr_o;
  logic             warn_o;
  logic [M-1:0]     fault_o;
  logic [M*CNT_W-1:0] err_cnt_o;

  modport slave (
    input  vld_i, vtr_i, mask_en_i, clr_i,
    output vld_o, vtr_o, warn_o, fault_o,
    output err_cnt_o
  );

  modport master (
    output vld_i, vtr_i, mask_en_i, clr_i,
    input  vld_o, vtr_o, warn_o, fault_o,
    input  err_cnt_o
  );
endinterface

// File: rtl/mvtr_rep_mon.sv
// One replica's health tracker: saturating mismatch count,
// consecutive-mismatch run length and sticky fault flag.
module mvtr_rep_mon
  import mvtr_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PERSIST = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             vld_i,
  input  logic             mism_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             fault_o
);

  localparam int RW = runlen_w(PERSIST);
  localparam logic [RW-1:0] PMAX = RW'(PERSIST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    run_q, run_d;
  logic             fault_q, fault_d;

  always_comb begin
    cnt_d   = cnt_q;
    run_d   = run_q;
    fault_d = fault_q;
    if (vld_i) begin
      if (mism_i) begin
        if (!(&cnt_q))
          cnt_d = cnt_q + CNT_W'(1);
        if (run_q != PMAX)
          run_d = run_q + RW'(1);
        if (run_d == PMAX)
          fault_d = 1'b1;
      end else begin
        run_d = '0;
      end
    end
    if (clr_i) begin
      cnt_d   = '0;
      run_d   = '0;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      run_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/mvtr_mon.sv
// M-way bitwise majority voter with per-replica fault tracking.
// Result, counters and fault flags all land one cycle after the sample.
module mvtr_mon
  import mvtr_pkg::*;
#(
  parameter int M       = 3,
  parameter int N       = 4,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 4
) (
  input logic  clk_i,
  input logic  rstn_i,
  mvtr_if.slave bus
);

  logic [M-1:0]       fault;
  logic [MAX_M-1:0]   act;
  logic [MAX_M-1:0]   bits;
  logic [N-1:0]       voted;
  logic [M-1:0]       mism;
  logic [M*CNT_W-1:0] cnt_w;

  logic               vld_q;
  logic [N-1:0]       vtr_q, vtr_d;
  logic               warn_q, warn_d;

  // An all-faulty mask would leave nothing to vote on; fall back to all.
  always_comb begin
    act = '0;
    act[M-1:0] = bus.mask_en_i ? ~fault : {M{1'b1}};
    if (act[M-1:0] == '0)
      act[M-1:0] = {M{1'b1}};
    voted = '0;
    bits  = '0;
    for (int j = 0; j < N; j++) begin
      bits = '0;
      for (int h = 0; h < M; h++)
        bits[h] = bus.vtr_i[h*N+j];
      voted[j] = maj_bit(bits, act);
    end
  end

  always_comb begin
    mism = '0;
    for (int h = 0; h < M; h++)
      mism[h] = (bus.vtr_i[h*N +: N] != voted);
  end

  always_comb begin
    vtr_d  = bus.vld_i ? voted : vtr_q;
    warn_d = bus.vld_i & (|mism);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q  <= 1'b0;
      vtr_q  <= '0;
      warn_q <= 1'b0;
    end else begin
      vld_q  <= bus.vld_i;
      vtr_q  <= vtr_d;
      warn_q <= warn_d;
    end
  end

  for (genvar h = 0; h < M; h++) begin : g_rep
    mvtr_rep_mon #(
      .CNT_W   (CNT_W),
      .PERSIST (PERSIST)
    ) u_rep (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .vld_i   (bus.vld_i),
      .mism_i  (mism[h]),
      .clr_i   (bus.clr_i),
      .cnt_o   (cnt_w[h*CNT_W +: CNT_W]),
      .fault_o (fault[h])
    );
  end

  assign bus.vld_o     = vld_q;
  assign bus.vtr_o     = vtr_q;
  assign bus.warn_o    = warn_q;
  assign bus.fault_o   = fault;
  assign bus.err_cnt_o = cnt_w;

endmodule
